// File: rtl/regfile_pkg.sv
// regfile_pkg -- shared definitions for the scoreboarded register file.
//   REGFILE_XLEN / REGFILE_NREG : default data width and register count
//   REGFILE_AW                  : address width for the default register count
//   reg_addr_t                  : register address type for the default build
//   addr_width()                : address width derivation for any register count
package regfile_pkg;

    localparam int REGFILE_XLEN = 64;
    localparam int REGFILE_NREG = 32;
    localparam int REGFILE_AW   = $clog2(REGFILE_NREG);

    typedef logic [REGFILE_AW-1:0] reg_addr_t;

    // A one-register file still needs a one-bit address.
    function automatic int addr_width(input int nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard -- one busy bit per register for in-order issue.
//   clk, rst        : clock, asynchronous active-low reset
//   wr_ena, wr_addr : writeback ports; each enabled port clears its register's busy bit
//   rsv_ena/addr    : destination reservation request from issue
//   flush           : clears every busy bit and refuses reservations
//   rsv_ok          : combinational grant for the reservation request
//   busy            : current busy vector (bit 0 is always 0)
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREG = REGFILE_NREG,
    parameter  int NWR  = 2,
    localparam int AW   = addr_width(NREG)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NWR-1:0]          wr_ena,
    input  logic [NWR-1:0][AW-1:0]  wr_addr,
    input  logic                    rsv_ena,
    input  logic [AW-1:0]           rsv_addr,
    input  logic                    flush,
    output logic                    rsv_ok,
    output logic [NREG-1:0]         busy
);

    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] busy_nxt_s;
    logic [NREG-1:0] clr_s;
    logic [NREG-1:0] set_s;
    logic            addr_free_s;

    // Reservation grant: x0 is always free; during reset every register reads as free.
    always_comb begin
        addr_free_s = (rsv_addr == {AW{1'b0}}) || !busy_r[rsv_addr];
        rsv_ok      = rsv_ena && (!rst || (addr_free_s && !flush));
    end

    // Next busy vector: a granted reservation overrides a same-cycle writeback clear.
    always_comb begin
        clr_s = {NREG{1'b0}};
        for (int i = 0; i < NWR; i++) begin
            clr_s[wr_addr[i]] = clr_s[wr_addr[i]] | wr_ena[i];
        end
        set_s           = {NREG{1'b0}};
        set_s[rsv_addr] = rsv_ok;
        busy_nxt_s      = flush ? {NREG{1'b0}} : (set_s | (busy_r & ~clr_s));
        busy_nxt_s[0]   = 1'b0;
    end

    // Busy-bit state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r <= {NREG{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    assign busy = busy_r;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb -- multi-ported register file with an issue scoreboard.
//   clk, rst          : clock, asynchronous active-low reset (zeros data and busy at once)
//   rd_addr/rd_data   : NRD combinational read ports; x0 always reads zero
//   rd_busy           : busy bit of each read address
//   wr_ena/addr/data  : NWR writeback ports; highest-index port wins on collision
//   rsv_ena/addr/ok   : destination reservation and its combinational grant
//   flush             : clears all reservations
// Build option: define REGFILE_SB_BYPASS_EN to forward same-cycle write data
// to matching reads (and report them not busy); otherwise reads see the
// pre-edge contents.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int XLEN = REGFILE_XLEN,
    parameter  int NREG = REGFILE_NREG,
    parameter  int NRD  = 2,
    parameter  int NWR  = 2,
    localparam int AW   = addr_width(NREG)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NRD-1:0][AW-1:0]   rd_addr,
    output logic [NRD-1:0][XLEN-1:0] rd_data,
    output logic [NRD-1:0]           rd_busy,
    input  logic [NWR-1:0]           wr_ena,
    input  logic [NWR-1:0][AW-1:0]   wr_addr,
    input  logic [NWR-1:0][XLEN-1:0] wr_data,
    input  logic                     rsv_ena,
    input  logic [AW-1:0]            rsv_addr,
    output logic                     rsv_ok,
    input  logic                     flush
);

    logic [XLEN-1:0] data_r [NREG];
    logic [NREG-1:0] busy_s;

    regfile_scoreboard #(
        .NREG (NREG),
        .NWR  (NWR)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .wr_ena   (wr_ena),
        .wr_addr  (wr_addr),
        .rsv_ena  (rsv_ena),
        .rsv_addr (rsv_addr),
        .flush    (flush),
        .rsv_ok   (rsv_ok),
        .busy     (busy_s)
    );

    // Data array: ascending port loop makes the highest-index port win a collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                data_r[r] <= {XLEN{1'b0}};
            end
        end else begin
            for (int i = 0; i < NWR; i++) begin
                if (wr_ena[i] && (wr_addr[i] != {AW{1'b0}})) begin
                    data_r[wr_addr[i]] <= wr_data[i];
                end
            end
        end
    end

    // Read muxing, with optional same-cycle forwarding from the write ports.
    always_comb begin
        rd_data = {(NRD*XLEN){1'b0}};
        rd_busy = {NRD{1'b0}};
        for (int p = 0; p < NRD; p++) begin
            if (rd_addr[p] != {AW{1'b0}}) begin
                rd_data[p] = data_r[rd_addr[p]];
                rd_busy[p] = busy_s[rd_addr[p]];
            end else begin
                rd_data[p] = {XLEN{1'b0}};
                rd_busy[p] = 1'b0;
            end
`ifdef REGFILE_SB_BYPASS_EN
            // Forwarding is suppressed during reset so reads stay zero.
            for (int w = 0; w < NWR; w++) begin
                rd_data[p] = (rst && wr_ena[w] && (rd_addr[p] != {AW{1'b0}}) &&
                              (wr_addr[w] == rd_addr[p])) ? wr_data[w] : rd_data[p];
                rd_busy[p] = (rst && wr_ena[w] && (rd_addr[p] != {AW{1'b0}}) &&
                              (wr_addr[w] == rd_addr[p])) ? 1'b0 : rd_busy[p];
            end
`endif
        end
    end

endmodule
